// File: rtl/cp_insert.sv
// Cyclic-prefix inserter for the OFDM transmit path.
// Buffers one N-sample symbol per bank (ping-pong). Each symbol is emitted as
// its last CP_LEN samples followed by all N samples. Both sides use valid/ready.
module cp_insert #(
    parameter int N          = 64,
    parameter int CP_LEN     = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop
);

    localparam int AW = $clog2(N);
    // Wide enough to hold N+CP_LEN-1 even when CP_LEN == N.
    localparam int CW = $clog2(N + CP_LEN + 1);

    localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(N + CP_LEN - 1);
    localparam logic [CW-1:0] CP_C    = CW'(CP_LEN);
    localparam logic [CW-1:0] BASE_C  = CW'(N - CP_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [2][N];

    logic            wr_sel;
    logic [AW-1:0]   wr_cnt;
    logic            rd_sel;
    logic [CW-1:0]   rd_cnt;
    logic [1:0]      full;
    rd_state_t       state;

    logic            wr_fire;
    logic            wr_done;
    logic            load;
    logic            rd_done;
    logic [AW-1:0]   rd_addr;

    logic [1:0]      full_nxt;
    logic            rd_sel_nxt;
    logic [CW-1:0]   rd_cnt_nxt;
    rd_state_t       state_nxt;

    assign in_ready = reset & ~full[wr_sel];
    assign wr_fire  = in_valid & in_ready;
    assign wr_done  = wr_fire & (wr_cnt == WR_LAST);
    assign load     = (~out_valid | out_ready) & full[rd_sel];
    assign rd_done  = load & (rd_cnt == RD_LAST);

    // Prefix words come from the tail of the bank, body words from its start.
    // The FSM state tells the two apart, so no wide compare sits on this path.
    assign rd_addr = (state == S_BODY) ? AW'(rd_cnt - CP_C) : AW'(rd_cnt + BASE_C);

    // Sample storage: plain register array, written on each accepted input.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_sel][wr_cnt] <= in;
        end
    end

    // Write-side bank pointer and sample counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sel <= 1'b0;
            wr_cnt <= '0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (wr_done) begin
                wr_sel <= ~wr_sel;
            end
        end
    end

    // Next-state for the bank-full flags and the read pointer; the writer and
    // reader always address different banks when both act on the same edge.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_sel] = 1'b0;
        end
        rd_sel_nxt = rd_sel ^ rd_done;
        rd_cnt_nxt = rd_cnt;
        if (load) begin
            rd_cnt_nxt = rd_done ? '0 : rd_cnt + CW'(1);
        end
        if (!full_nxt[rd_sel_nxt]) begin
            state_nxt = S_IDLE;
        end else if (rd_cnt_nxt < CP_C) begin
            state_nxt = S_CP;
        end else begin
            state_nxt = S_BODY;
        end
    end

    // Read FSM with registered output word, valid and frame markers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full      <= 2'b00;
            rd_sel    <= 1'b0;
            rd_cnt    <= '0;
            state     <= S_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            full   <= full_nxt;
            rd_sel <= rd_sel_nxt;
            rd_cnt <= rd_cnt_nxt;
            state  <= state_nxt;
            if (load) begin
                out       <= mem[rd_sel][rd_addr];
                out_valid <= 1'b1;
                out_sop   <= (rd_cnt == '0);
                out_eop   <= (rd_cnt == RD_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp_insert.sv
// Self-checking bench for cp_insert: a scenario table for the N=64/CP=16
// instance, a mid-symbol reset sequence, and a CP_LEN==N instance (N=16).
module tb_cp_insert;

    localparam int N    = 64;
    localparam int CPL  = 16;
    localparam int DW   = 16;
    localparam int N2   = 16;
    localparam int CPL2 = 16;

    logic          clk = 1'b0;
    logic          reset;

    logic [DW-1:0] a_in;
    logic          a_in_valid;
    logic          a_in_ready;
    logic [DW-1:0] a_out;
    logic          a_out_valid;
    logic          a_out_ready;
    logic          a_out_sop;
    logic          a_out_eop;

    logic [DW-1:0] b_in;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [DW-1:0] b_out;
    logic          b_out_valid;
    logic          b_out_ready;
    logic          b_out_sop;
    logic          b_out_eop;

    cp_insert #(.N(N), .CP_LEN(CPL), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .reset(reset),
        .in(a_in), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out(a_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sop(a_out_sop), .out_eop(a_out_eop)
    );

    cp_insert #(.N(N2), .CP_LEN(CPL2), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .reset(reset),
        .in(b_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out(b_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sop(b_out_sop), .out_eop(b_out_eop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int nsym;
        int base;
        int ready_pct;
        int gap_pct;
        bit gapless;
        bit exp_bp;
        int exp_words;
        int exp_first;
        int exp_last;
    } scen_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            sop;
        bit            eop;
    } word_t;

    word_t expq[$];

    int      acc_cyc;
    int      last_acc;
    bit      saw_bp;
    int      got;
    int      first_valid_cyc;
    int      gap_err;
    int      extra;
    int      first_word;
    int      last_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] v, input int gap_pct);
        int t;
        @(negedge clk);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            a_in_valid = 1'b0;
            @(negedge clk);
        end
        a_in       = v;
        a_in_valid = 1'b1;
        t = 0;
        while (!a_in_ready && t < 2000) begin
            saw_bp = 1'b1;
            @(negedge clk);
            t++;
        end
        check("in_accept", {31'd0, a_in_ready}, 32'd1);
        last_acc = cyc + 1;
    endtask

    task automatic drive_symbols(input scen_t sc);
        for (int s = 0; s < sc.nsym; s++) begin
            for (int j = 0; j < N; j++) begin
                send_sample(DW'(sc.base + N * s + j), sc.gap_pct);
                if (s == 0 && j == N - 1) acc_cyc = last_acc;
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic monitor(input int total, input int ready_pct, input bit gapless);
        bit    stall;
        bit    r;
        word_t prev;
        word_t e;
        int    idle_after;
        stall           = 1'b0;
        idle_after      = 0;
        got             = 0;
        first_valid_cyc = -1;
        gap_err         = 0;
        extra           = 0;
        prev            = '{d: '0, sop: 1'b0, eop: 1'b0};
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (stall) begin
                check("hold_valid", {31'd0, a_out_valid}, 32'd1);
                check("hold_data", {16'd0, a_out}, {16'd0, prev.d});
                check("hold_sop", {31'd0, a_out_sop}, {31'd0, prev.sop});
                check("hold_eop", {31'd0, a_out_eop}, {31'd0, prev.eop});
            end
            if (a_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (gapless && first_valid_cyc >= 0 && got < total && !a_out_valid) gap_err++;
            if (got >= total) begin
                if (a_out_valid) extra++;
                idle_after++;
                if (idle_after >= 20) break;
            end
            r = (got >= total) ? 1'b1 : ($urandom_range(99) < ready_pct);
            a_out_ready = r;
            if (a_out_valid && r && got < total) begin
                e = expq[got];
                check("out_data", {16'd0, a_out}, {16'd0, e.d});
                check("out_sop", {31'd0, a_out_sop}, {31'd0, e.sop});
                check("out_eop", {31'd0, a_out_eop}, {31'd0, e.eop});
                if (got == 0) first_word = int'(a_out);
                last_word = int'(a_out);
                got++;
            end
            stall = a_out_valid && !r;
            prev  = '{d: a_out, sop: a_out_sop, eop: a_out_eop};
        end
    endtask

    task automatic run_scen(input scen_t sc);
        expq.delete();
        for (int s = 0; s < sc.nsym; s++) begin
            for (int j = 0; j < CPL; j++)
                expq.push_back('{d: DW'(sc.base + N * s + N - CPL + j), sop: (j == 0), eop: 1'b0});
            for (int j = 0; j < N; j++)
                expq.push_back('{d: DW'(sc.base + N * s + j), sop: 1'b0, eop: (j == N - 1)});
        end
        saw_bp     = 1'b0;
        first_word = -1;
        last_word  = -1;
        acc_cyc    = -100;
        fork
            drive_symbols(sc);
            monitor(expq.size(), sc.ready_pct, sc.gapless);
        join
        check("word_count", got, sc.exp_words);
        check("first_word", first_word, sc.exp_first);
        check("last_word", last_word, sc.exp_last);
        check("latency", first_valid_cyc, acc_cyc + 1);
        check("in_backpressure", {31'd0, saw_bp}, {31'd0, sc.exp_bp});
        check("extra_words", extra, 0);
        if (sc.gapless) check("output_gaps", gap_err, 0);
    endtask

    scen_t tbl[4];
    scen_t rst_sc;

    initial begin
        int t;
        int k;
        tbl[0] = '{1,    0, 100,  0, 1'b1, 1'b0,  80,   48,   63};
        tbl[1] = '{4,    0, 100,  0, 1'b1, 1'b1, 320,   48,  255};
        tbl[2] = '{3, 1000,  50,  0, 1'b0, 1'b1, 240, 1048, 1191};
        tbl[3] = '{1,    0, 100, 30, 1'b1, 1'b0,  80,   48,   63};
        rst_sc = '{1,  100, 100,  0, 1'b1, 1'b0,  80,  148,  163};

        reset       = 1'b0;
        a_in        = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in        = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out", {16'd0, a_out}, 32'd0);
        check("rst_sop", {31'd0, a_out_sop}, 32'd0);
        check("rst_eop", {31'd0, a_out_eop}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, a_out_valid}, 32'd0);

        for (int i = 0; i < 4; i++) run_scen(tbl[i]);

        // Reset in the middle of a symbol discards the partial data
        for (int j = 0; j < 40; j++) send_sample(DW'(500 + j), 0);
        @(negedge clk);
        a_in_valid = 1'b0;
        check("partial_no_output", {31'd0, a_out_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, a_in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("after_midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
        run_scen(rst_sc);

        // CP_LEN == N: prefix is a full copy of the symbol
        for (int j = 0; j < N2; j++) begin
            @(negedge clk);
            b_in       = DW'(j);
            b_in_valid = 1'b1;
            t = 0;
            while (!b_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("b_in_accept", {31'd0, b_in_ready}, 32'd1);
        end
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 2 * N2; c++) begin
            if (b_out_valid) begin
                check("b_out_data", {16'd0, b_out}, k % N2);
                check("b_out_sop", {31'd0, b_out_sop}, {31'd0, (k == 0)});
                check("b_out_eop", {31'd0, b_out_eop}, {31'd0, (k == 2 * N2 - 1)});
                k++;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("b_word_count", k, 2 * N2);
        check("b_idle_after", {31'd0, b_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
